// File: rtl/bullet_engine_if.sv
// bullet_engine_if: tile map bus between the bullet engine and the map store.
// Read: tile_addr -> tile_data (1-cycle latency). Write: wr_en/wr_addr/wr_data.
interface bullet_engine_if;
    logic [8:0] tile_addr;
    logic [2:0] tile_data;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [2:0] wr_data;

    modport master (
        output tile_addr,
        output wr_en,
        output wr_addr,
        output wr_data,
        input  tile_data
    );

    modport slave (
        input  tile_addr,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output tile_data
    );
endinterface

// File: rtl/bullet_engine.sv
// bullet_engine: one bullet per player; spawns at the tank, moves per frame,
// resolves walls/bases through the tile map.
// Ports: Clk, Reset_n, frame_tick, fire, dir, TankX/Y in; map bus (master);
//        BulletX/Y, bullet_active, base_hit out.
module bullet_engine #(
    parameter int SPEED      = 4,
    parameter int TILE_SHIFT = 5,
    parameter int MAP_W      = 20
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            frame_tick,
    input  logic            fire,
    input  logic [1:0]      dir,
    input  logic [9:0]      TankX,
    input  logic [9:0]      TankY,
    bullet_engine_if.master map,
    output logic [9:0]      BulletX,
    output logic [9:0]      BulletY,
    output logic            bullet_active,
    output logic [1:0]      base_hit
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_MOVE,
        S_LOOKUP,
        S_WAIT,
        S_CHECK
    } state_t;

    localparam logic signed [10:0] STEP  = 11'(SPEED);
    localparam logic [9:0]         MAP_K = 10'(MAP_W);

    state_t state;
    state_t state_nx;

    logic       fire_d;
    logic       fire_pending;
    logic       live;
    logic [1:0] dir_q;
    logic [8:0] addr_q;

    logic              spawn;
    logic              off;
    logic              retire_now;
    logic              in_check;
    logic signed [10:0] nx;
    logic signed [10:0] ny;
    logic [9:0]        row;
    logic [9:0]        col;
    logic [8:0]        addr_sum;

    assign spawn    = (state == S_IDLE) && frame_tick && fire_pending;
    assign in_check = (state == S_CHECK);

    // Next position in signed 11-bit so that underflow shows as negative.
    always_comb begin
        nx = $signed({1'b0, BulletX});
        ny = $signed({1'b0, BulletY});
        unique case (dir_q)
            2'd0: ny = ny - STEP;
            2'd1: nx = nx + STEP;
            2'd2: ny = ny + STEP;
            2'd3: nx = nx - STEP;
        endcase
    end

    assign off = (nx < 11'sd0) || (ny < 11'sd0) ||
                 (nx > 11'sd639) || (ny > 11'sd479);

    // row*MAP_W as a sum of shifted rows, one term per set bit of MAP_W.
    always_comb begin
        row      = BulletY >> TILE_SHIFT;
        col      = BulletX >> TILE_SHIFT;
        addr_sum = 9'(col);
        for (int i = 0; i < 10; i++) begin
            if (MAP_K[i]) begin
                addr_sum = addr_sum + 9'(row << i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (spawn) state_nx = S_LOOKUP;
            S_ACTIVE: if (frame_tick) state_nx = S_MOVE;
            S_MOVE:   state_nx = off ? S_IDLE : S_LOOKUP;
            S_LOOKUP: state_nx = S_WAIT;
            S_WAIT:   state_nx = S_CHECK;
            S_CHECK:  begin
                if (map.tile_data == 3'd0) begin
                    state_nx = S_ACTIVE;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    // Hit strobes are decoded straight from the RAM data during CHECK so
    // they last exactly one cycle and vanish with an asynchronous reset.
    assign retire_now = in_check && (map.tile_data != 3'd0);
    assign map.wr_en  = in_check && (map.tile_data == 3'd2);
    assign map.wr_addr = map.wr_en ? addr_q : 9'd0;
    assign map.wr_data = 3'd0;
    assign map.tile_addr = addr_q;
    assign base_hit[0] = in_check && (map.tile_data == 3'd3);
    assign base_hit[1] = in_check && (map.tile_data == 3'd4);

    // The bullet drops out of view in the same cycle it resolves.
    assign bullet_active = live && !retire_now;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fire_d       <= 1'b0;
            fire_pending <= 1'b0;
            live         <= 1'b0;
            dir_q        <= 2'd0;
            addr_q       <= 9'd0;
            BulletX      <= 10'd0;
            BulletY      <= 10'd0;
        end else begin
            fire_d <= fire;

            // A spawn consumes the request; edges coinciding with it are lost.
            if (spawn) begin
                fire_pending <= 1'b0;
            end else if ((state == S_IDLE) && fire && !fire_d) begin
                fire_pending <= 1'b1;
            end

            if (spawn) begin
                BulletX <= TankX;
                BulletY <= TankY;
                dir_q   <= dir;
                live    <= 1'b1;
            end

            if (state == S_MOVE) begin
                if (off) begin
                    live <= 1'b0;
                end else begin
                    BulletX <= nx[9:0];
                    BulletY <= ny[9:0];
                end
            end

            if (state == S_LOOKUP) begin
                addr_q <= addr_sum;
            end

            if (retire_now) begin
                live <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bullet_engine.sv
// tb_bullet_engine: directed stimulus, event-scheduled reference model,
// per-cycle output comparison and literal checks on key scenarios.
module tb_bullet_engine;

    localparam int SPEED = 4;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       fire;
    logic [1:0] dir;
    logic [9:0] tank_x;
    logic [9:0] tank_y;
    logic [9:0] bullet_x;
    logic [9:0] bullet_y;
    logic       bullet_active;
    logic [1:0] base_hit;

    bullet_engine_if map_bus ();

    bullet_engine #(.SPEED(SPEED), .TILE_SHIFT(5), .MAP_W(20)) dut (
        .Clk           (clk),
        .Reset_n       (rst_n),
        .frame_tick    (frame_tick),
        .fire          (fire),
        .dir           (dir),
        .TankX         (tank_x),
        .TankY         (tank_y),
        .map           (map_bus),
        .BulletX       (bullet_x),
        .BulletY       (bullet_y),
        .bullet_active (bullet_active),
        .base_hit      (base_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tile RAM: registered read, write-back on wr_en.
    logic [2:0] ram [512];
    always @(posedge clk) begin
        map_bus.tile_data <= ram[map_bus.tile_addr];
        if (map_bus.wr_en) ram[map_bus.wr_addr] <= map_bus.wr_data;
    end

    int checks = 0;
    int errors = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bullet events scheduled by absolute edge number.
    int mmap [512];
    int cyc = 0;
    int m_x = 0, m_y = 0, m_dir = 0, m_addr = 0, m_tile = 0;
    bit m_fly = 0, m_busy = 0, m_act = 0, m_pend = 0, m_fd = 0, m_wr = 0;
    logic [1:0] m_hit = 2'b00;
    int t_pos = -1, t_addr = -1, t_chk = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_x = 0; m_y = 0; m_addr = 0; m_tile = 0;
            m_fly = 0; m_busy = 0; m_act = 0; m_pend = 0; m_fd = 0;
            m_wr = 0; m_hit = 2'b00;
            t_pos = -1; t_addr = -1; t_chk = -1;
        end else begin
            bit fly0, busy0, pend0;
            int nx, ny;
            cyc++;
            fly0 = m_fly; busy0 = m_busy; pend0 = m_pend;
            m_wr = 0; m_hit = 2'b00;
            if (t_chk == cyc - 1 && t_chk >= 0) begin
                if (m_tile == 2) mmap[m_addr] = 0;
                m_busy = 0;
                if (m_tile != 0) m_fly = 0;
                t_chk = -1;
            end
            if (t_pos == cyc) begin
                nx = m_x; ny = m_y;
                case (m_dir)
                    0: ny = ny - SPEED;
                    1: nx = nx + SPEED;
                    2: ny = ny + SPEED;
                    default: nx = nx - SPEED;
                endcase
                if (nx < 0 || ny < 0 || nx > 639 || ny > 479) begin
                    m_act = 0; m_fly = 0; m_busy = 0;
                end else begin
                    m_x = nx; m_y = ny;
                    t_addr = cyc + 1; t_chk = cyc + 2;
                end
                t_pos = -1;
            end
            if (t_addr == cyc) begin
                m_addr = (m_y / 32) * 20 + (m_x / 32);
                t_addr = -1;
            end
            if (t_chk == cyc) begin
                m_tile = mmap[m_addr];
                m_wr = (m_tile == 2);
                m_hit = {m_tile == 4, m_tile == 3};
                if (m_tile != 0) m_act = 0;
            end
            if (fly0 && !busy0 && frame_tick) begin
                m_busy = 1; t_pos = cyc + 1;
            end
            if (!fly0 && pend0 && frame_tick) begin
                m_x = tank_x; m_y = tank_y; m_dir = dir;
                m_act = 1; m_fly = 1; m_busy = 1; m_pend = 0;
                t_addr = cyc + 1; t_chk = cyc + 2;
            end else if (!fly0 && fire && !m_fd) begin
                m_pend = 1;
            end
            m_fd = fire;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("bullet_active", 32'(bullet_active), 32'(m_act));
            chk("BulletX", 32'(bullet_x), 32'(m_x));
            chk("BulletY", 32'(bullet_y), 32'(m_y));
            chk("tile_addr", 32'(map_bus.tile_addr), 32'(m_addr));
            chk("wr_en", 32'(map_bus.wr_en), 32'(m_wr));
            chk("wr_addr", 32'(map_bus.wr_addr), m_wr ? 32'(m_addr) : 32'd0);
            chk("wr_data", 32'(map_bus.wr_data), 32'd0);
            chk("base_hit", 32'(base_hit), 32'(m_hit));
        end
    end

    int wr_pulses = 0, hit_pulses = 0, last_wr_addr = -1;
    logic [1:0] last_hit = 2'b00;
    always @(negedge clk) begin
        if (map_bus.wr_en === 1'b1) begin
            wr_pulses++; last_wr_addr = map_bus.wr_addr;
        end
        if (base_hit !== 2'b00 && base_hit !== 2'bxx) begin
            hit_pulses++; last_hit = base_hit;
        end
    end

    task automatic set_tile(input int a, input int v);
        ram[a] = 3'(v);
        mmap[a] = v;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_fire();
        @(negedge clk) fire = 1'b1;
        @(negedge clk) fire = 1'b0;
    endtask

    task automatic tick(input int gap);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        cycles(gap);
    endtask

    // Tick and report how many negedges later the first strobe appears.
    task automatic tick_watch(output int delta);
        delta = 0;
        @(negedge clk) frame_tick = 1'b1;
        for (int d = 1; d <= 8; d++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (delta == 0 && (map_bus.wr_en === 1'b1 || base_hit != 2'b00))
                delta = d;
        end
    endtask

    int delta;
    int n;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) set_tile(i, 0);
        rst_n = 1'b1; frame_tick = 1'b0; fire = 1'b0; dir = 2'd0;
        tank_x = 10'd0; tank_y = 10'd0;
        #2 rst_n = 1'b0;
        started = 1;
        cycles(3);
        chk("reset active", 32'(bullet_active), 32'd0);
        chk("reset tile_addr", 32'(map_bus.tile_addr), 32'd0);
        chk("reset BulletX", 32'(bullet_x), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        cycles(2);

        // Open map, moving right, then a border wall at tile 44.
        set_tile(44, 1);
        tank_x = 10'd100; tank_y = 10'd80; dir = 2'd1;
        pulse_fire();
        tick(8);
        chk("t1 spawn X", 32'(bullet_x), 32'd100);
        tick(8);
        tick(8);
        chk("t1 X after 3 ticks", 32'(bullet_x), 32'd108);
        chk("t1 Y", 32'(bullet_y), 32'd80);
        chk("t1 active", 32'(bullet_active), 32'd1);
        chk("t1 tile_addr", 32'(map_bus.tile_addr), 32'd43);
        n = 0;
        while (bullet_active && n < 40) begin
            tick(3);
            n++;
        end
        cycles(6);
        chk("t1 retired", 32'(bullet_active), 32'd0);
        chk("t1 stop X", 32'(bullet_x), 32'd128);
        chk("t1 no writes", 32'(wr_pulses), 32'd0);

        // Destructible wall at row 3 col 8.
        set_tile(68, 2);
        tank_x = 10'd272; tank_y = 10'd112; dir = 2'd0;
        pulse_fire();
        tick_watch(delta);
        chk("t2 wr latency", 32'(delta), 32'd3);
        chk("t2 wr count", 32'(wr_pulses), 32'd1);
        chk("t2 wr addr", 32'(last_wr_addr), 32'd68);
        chk("t2 tile cleared", 32'(ram[68]), 32'd0);
        chk("t2 active", 32'(bullet_active), 32'd0);

        // Base (tile 4) one step below the spawn tile.
        set_tile(41, 4);
        tank_x = 10'd48; tank_y = 10'd60; dir = 2'd2;
        pulse_fire();
        tick(8);
        chk("t3 spawn active", 32'(bullet_active), 32'd1);
        tick_watch(delta);
        chk("t3 hit latency", 32'(delta), 32'd4);
        chk("t3 hit value", 32'(last_hit), 32'd2);
        chk("t3 hit count", 32'(hit_pulses), 32'd1);
        chk("t3 no write", 32'(wr_pulses), 32'd1);
        chk("t3 active", 32'(bullet_active), 32'd0);

        // Left screen edge.
        tank_x = 10'd2; tank_y = 10'd200; dir = 2'd3;
        pulse_fire();
        tick(8);
        chk("t4 spawn addr", 32'(map_bus.tile_addr), 32'd120);
        tick(8);
        chk("t4 active", 32'(bullet_active), 32'd0);
        chk("t4 addr held", 32'(map_bus.tile_addr), 32'd120);
        chk("t4 X held", 32'(bullet_x), 32'd2);

        // Single bullet: fire rises mid-flight and is held through retire.
        set_tile(190, 1);
        tank_x = 10'd300; tank_y = 10'd300; dir = 2'd1;
        pulse_fire();
        tick(8);
        tick(8);
        @(negedge clk) fire = 1'b1;
        n = 0;
        while (bullet_active && n < 20) begin
            tick(8);
            n++;
        end
        chk("t5 stop X", 32'(bullet_x), 32'd320);
        tick(8);
        chk("t5 no respawn", 32'(bullet_active), 32'd0);

        // Fresh edge spawns on a wall tile; reset lands in WAIT.
        set_tile(252, 2);
        tank_x = 10'd400; tank_y = 10'd400; dir = 2'd0;
        @(negedge clk) fire = 1'b0;
        pulse_fire();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        chk("t6 spawned", 32'(bullet_active), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst active", 32'(bullet_active), 32'd0);
        chk("t6 rst X", 32'(bullet_x), 32'd0);
        chk("t6 rst wr_en", 32'(map_bus.wr_en), 32'd0);
        chk("t6 rst base_hit", 32'(base_hit), 32'd0);
        chk("t6 rst tile_addr", 32'(map_bus.tile_addr), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick(8);
        tick(8);
        chk("t6 no write", 32'(wr_pulses), 32'd1);
        chk("t6 tile kept", 32'(ram[252]), 32'd2);
        chk("t6 no hit", 32'(hit_pulses), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
